regfile_arbiter: RTL and testbench

//  Shares the GPIO/ID register file between two requesters: m0 = core load/store port, m1 = debug/SPI host port.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/regfile_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, state type and access check for the register-file arbiter
package regfile_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CNAME    = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_CVERSION = 7'h01;
  localparam logic [ADDR_W-1:0] PORT_BASE     = 7'h02;
  localparam int                REGS_PER_PORT = 5;
  localparam int                NUM_PORTS     = 16;
  localparam logic [ADDR_W-1:0] ADDR_LAST     = ADDR_W'(PORT_BASE + NUM_PORTS * REGS_PER_PORT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  // ID words below ro_top accept reads only; anything past max_addr is unmapped
  function automatic logic access_ok(input logic r_wn, input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] ro_top,
                                     input logic [ADDR_W-1:0] max_addr);
    return (addr <= max_addr) && (r_wn || (addr >= ro_top));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a last-served pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_done_id,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  logic r_last;

  // Reset to "m1 served last" so the first tie goes to m0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_done) begin
      r_last <= i_done_id;
    end
  end

  assign o_gnt_valid = |i_req;
  assign o_gnt_id    = (&i_req) ? ~r_last : i_req[1];

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - serialises core and debug accesses onto one registered register-file port
module regfile_arbiter #(
  parameter int                              ADDR_W   = regfile_pkg::ADDR_W,
  parameter int                              DATA_W   = regfile_pkg::DATA_W,
  parameter int                              RD_LAT   = 1,
  parameter logic [regfile_pkg::ADDR_W-1:0]  RO_TOP   = regfile_pkg::PORT_BASE,
  parameter logic [regfile_pkg::ADDR_W-1:0]  MAX_ADDR = regfile_pkg::ADDR_LAST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_r_wn,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_r_wn,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_rf_en,
  output logic              o_rf_r_wn,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic [DATA_W-1:0] o_rf_wdata,
  input  logic [DATA_W-1:0] i_rf_rdata
);

  import regfile_pkg::*;

  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  state_e            r_state;
  logic              r_gnt;
  logic              r_ok;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rf_en;
  logic              r_rf_r_wn;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_m0_ack;
  logic              r_m0_err;
  logic [DATA_W-1:0] r_m0_rdata;
  logic              r_m1_ack;
  logic              r_m1_err;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_done;
  logic              w_sel_r_wn;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_ok;

  assign w_done = (r_state == RESP);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      ({i_m1_req, i_m0_req}),
    .i_done     (w_done),
    .i_done_id  (r_gnt),
    .o_gnt_valid(w_gnt_valid),
    .o_gnt_id   (w_gnt_id)
  );

  assign w_sel_r_wn  = w_gnt_id ? i_m1_r_wn  : i_m0_r_wn;
  assign w_sel_addr  = w_gnt_id ? i_m1_addr  : i_m0_addr;
  assign w_sel_wdata = w_gnt_id ? i_m1_wdata : i_m0_wdata;
  assign w_sel_ok    = access_ok(w_sel_r_wn, w_sel_addr, RO_TOP, MAX_ADDR);

  // Legality is resolved while latching so rf_en can be a plain register in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_ok       <= 1'b0;
      r_cnt      <= '0;
      r_rf_en    <= 1'b0;
      r_rf_r_wn  <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
      r_m0_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_ack   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
    end else begin
      r_rf_en  <= 1'b0;
      r_m0_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m1_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt      <= w_gnt_id;
            r_rf_r_wn  <= w_sel_r_wn;
            r_rf_addr  <= w_sel_addr;
            r_rf_wdata <= w_sel_wdata;
            r_ok       <= w_sel_ok;
            r_rf_en    <= w_sel_ok;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_ok && r_rf_r_wn) begin
            r_cnt   <= CNT_W'(RD_LAT);
            r_state <= WAIT;
          end else begin
            r_state <= RESP;
            if (r_gnt) begin
              r_m1_ack <= 1'b1;
              r_m1_err <= ~r_ok;
              if (!r_ok && r_rf_r_wn) r_m1_rdata <= '0;
            end else begin
              r_m0_ack <= 1'b1;
              r_m0_err <= ~r_ok;
              if (!r_ok && r_rf_r_wn) r_m0_rdata <= '0;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= RESP;
            if (r_gnt) begin
              r_m1_ack   <= 1'b1;
              r_m1_rdata <= i_rf_rdata;
            end else begin
              r_m0_ack   <= 1'b1;
              r_m0_rdata <= i_rf_rdata;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_rf_en    = r_rf_en;
  assign o_rf_r_wn  = r_rf_r_wn;
  assign o_rf_addr  = r_rf_addr;
  assign o_rf_wdata = r_rf_wdata;
  assign o_m0_ack   = r_m0_ack;
  assign o_m0_err   = r_m0_err;
  assign o_m0_rdata = r_m0_rdata;
  assign o_m1_ack   = r_m1_ack;
  assign o_m1_err   = r_m1_err;
  assign o_m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - transaction-schedule model check of regfile_arbiter at RD_LAT 1 and 3
module tb_regfile_arbiter;

  localparam logic [6:0] RO_TOP = 7'h02;
  localparam logic [6:0] MAXA   = 7'h51;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot  = 0;

  logic        req   [2][2];
  logic        rwn   [2][2];
  logic [6:0]  addr  [2][2];
  logic [31:0] wd    [2][2];
  logic        ack   [2][2];
  logic        err   [2][2];
  logic [31:0] rdata [2][2];
  logic        rf_en    [2];
  logic        rf_rwn   [2];
  logic [6:0]  rf_addr  [2];
  logic [31:0] rf_wdata [2];
  logic [31:0] rf_rdata [2];
  logic [31:0] rdhist [2][64];
  bit          fix_on [2];
  logic [31:0] fix_val;
  bit          ack_prev [2][2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_arbiter #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_m0_req(req[0][0]), .i_m0_r_wn(rwn[0][0]), .i_m0_addr(addr[0][0]), .i_m0_wdata(wd[0][0]),
    .o_m0_ack(ack[0][0]), .o_m0_err(err[0][0]), .o_m0_rdata(rdata[0][0]),
    .i_m1_req(req[0][1]), .i_m1_r_wn(rwn[0][1]), .i_m1_addr(addr[0][1]), .i_m1_wdata(wd[0][1]),
    .o_m1_ack(ack[0][1]), .o_m1_err(err[0][1]), .o_m1_rdata(rdata[0][1]),
    .o_rf_en(rf_en[0]), .o_rf_r_wn(rf_rwn[0]), .o_rf_addr(rf_addr[0]), .o_rf_wdata(rf_wdata[0]),
    .i_rf_rdata(rf_rdata[0])
  );

  regfile_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_m0_req(req[1][0]), .i_m0_r_wn(rwn[1][0]), .i_m0_addr(addr[1][0]), .i_m0_wdata(wd[1][0]),
    .o_m0_ack(ack[1][0]), .o_m0_err(err[1][0]), .o_m0_rdata(rdata[1][0]),
    .i_m1_req(req[1][1]), .i_m1_r_wn(rwn[1][1]), .i_m1_addr(addr[1][1]), .i_m1_wdata(wd[1][1]),
    .o_m1_ack(ack[1][1]), .o_m1_err(err[1][1]), .o_m1_rdata(rdata[1][1]),
    .o_rf_en(rf_en[1]), .o_rf_r_wn(rf_rwn[1]), .o_rf_addr(rf_addr[1]), .o_rf_wdata(rf_wdata[1]),
    .i_rf_rdata(rf_rdata[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      rf_rdata[k] = fix_on[k] ? fix_val : $urandom;
      rdhist[k][cyc % 64] = rf_rdata[k];
    end
  end

  // Model: each accepted transaction becomes a schedule of cycles (rf_en, ack) and a data source cycle
  int          m_idle_at [2];
  bit          m_pend    [2];
  bit          m_gnt     [2];
  bit          m_last    [2];
  bit          m_legal   [2];
  bit          m_rd      [2];
  int          m_s       [2];
  int          m_ack     [2];
  logic [6:0]  m_addr    [2];
  logic [31:0] m_wd      [2];
  logic [31:0] m_rdata   [2][2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk("rst_ctl", k, {58'd0, ack[k][0], err[k][0], ack[k][1], err[k][1], rf_en[k], rf_rwn[k]}, 64'd0);
        chk("rst_addr", k, {57'd0, rf_addr[k]}, 64'd0);
        chk("rst_wdata", k, {32'd0, rf_wdata[k]}, 64'd0);
        chk("rst_rdata", k, {rdata[k][1], rdata[k][0]}, 64'd0);
        m_pend[k] = 0;
        m_last[k] = 1;
        m_rdata[k][0] = 0;
        m_rdata[k][1] = 0;
        m_idle_at[k] = cyc + 1;
        ack_prev[k][0] = 0;
        ack_prev[k][1] = 0;
      end else begin
        bit exp_en;
        exp_en = m_pend[k] && m_legal[k] && (cyc == m_s[k] + 1);
        chk("rf_en", k, {63'd0, rf_en[k]}, {63'd0, exp_en});
        if (exp_en) begin
          chk("rf_r_wn", k, {63'd0, rf_rwn[k]}, {63'd0, m_rd[k]});
          chk("rf_addr", k, {57'd0, rf_addr[k]}, {57'd0, m_addr[k]});
          chk("rf_wdata", k, {32'd0, rf_wdata[k]}, {32'd0, m_wd[k]});
        end
        for (int n = 0; n < 2; n++) begin
          bit exp_ack;
          exp_ack = m_pend[k] && (m_gnt[k] == n[0]) && (cyc == m_ack[k]);
          if (exp_ack && m_rd[k])
            m_rdata[k][n] = m_legal[k] ? rdhist[k][(m_s[k] + 1 + lat(k)) % 64] : 32'd0;
          chk("ack", k, {63'd0, ack[k][n]}, {63'd0, exp_ack});
          chk("err", k, {63'd0, err[k][n]}, {63'd0, exp_ack && !m_legal[k]});
          chk("rdata", k, {32'd0, rdata[k][n]}, {32'd0, m_rdata[k][n]});
          ack_prev[k][n] = ack[k][n];
        end
        if (m_pend[k] && cyc == m_ack[k]) begin
          m_pend[k] = 0;
          m_last[k] = m_gnt[k];
        end
        if (!m_pend[k] && cyc >= m_idle_at[k] && (req[k][0] || req[k][1])) begin
          bit g;
          g = (req[k][0] && req[k][1]) ? !m_last[k] : req[k][1];
          m_gnt[k]   = g;
          m_rd[k]    = rwn[k][g];
          m_addr[k]  = addr[k][g];
          m_wd[k]    = wd[k][g];
          m_legal[k] = (m_addr[k] <= MAXA) && (m_rd[k] || m_addr[k] >= RO_TOP);
          m_s[k]     = cyc;
          m_ack[k]   = cyc + 2 + ((m_legal[k] && m_rd[k]) ? lat(k) : 0);
          m_idle_at[k] = m_ack[k] + 1;
          m_pend[k]  = 1;
        end
      end
    end
  end

  task automatic txn(input string tag, input int k, input int n, input bit rw, input logic [6:0] a,
                     input logic [31:0] d, input int en_off, input int ack_off, input bit e_err,
                     input int hist_off, input logic [31:0] e_rd);
    int s, en_at, ack_at;
    logic got_err, got_rwn;
    logic [6:0] got_a;
    logic [31:0] got_rd, got_wd;
    @(posedge clk); #1;
    req[k][n] = 1; rwn[k][n] = rw; addr[k][n] = a; wd[k][n] = d;
    s = cyc; en_at = -1; ack_at = -1;
    got_err = 0; got_rd = 0; got_rwn = 0; got_a = 0; got_wd = 0;
    for (int i = 0; i < 12 && ack_at < 0; i++) begin
      @(negedge clk);
      if (rf_en[k] === 1'b1 && en_at < 0) begin
        en_at = cyc - s; got_rwn = rf_rwn[k]; got_a = rf_addr[k]; got_wd = rf_wdata[k];
      end
      if (ack[k][n] === 1'b1) begin
        ack_at = cyc - s; got_err = err[k][n]; got_rd = rdata[k][n];
      end
      @(posedge clk); #1;
    end
    req[k][n] = 0;
    chk({tag, "_en_cycle"}, k, 64'(en_at), 64'(en_off));
    if (en_off >= 0) begin
      chk({tag, "_rf_r_wn"}, k, {63'd0, got_rwn}, {63'd0, rw});
      chk({tag, "_rf_addr"}, k, {57'd0, got_a}, {57'd0, a});
      if (!rw) chk({tag, "_rf_wdata"}, k, {32'd0, got_wd}, {32'd0, d});
    end
    chk({tag, "_ack_cycle"}, k, 64'(ack_at), 64'(ack_off));
    chk({tag, "_err"}, k, {63'd0, got_err}, {63'd0, e_err});
    if (hist_off >= 0) chk({tag, "_rdata"}, k, {32'd0, got_rd}, {32'd0, rdhist[k][(s + hist_off) % 64]});
    else if (hist_off == -1) chk({tag, "_rdata"}, k, {32'd0, got_rd}, {32'd0, e_rd});
  endtask

  task automatic new_fields(input int k, input int n);
    rwn[k][n] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: addr[k][n] = 7'h00;
      1: addr[k][n] = 7'h01;
      2: addr[k][n] = RO_TOP;
      3: addr[k][n] = MAXA;
      4: addr[k][n] = MAXA + 7'd1;
      5: addr[k][n] = 7'($urandom_range(0, 127));
      default: addr[k][n] = 7'($urandom_range(2, 81));
    endcase
    wd[k][n] = $urandom;
  endtask

  initial begin
    int order[$];
    int both;
    int s5;
    rst_n = 0;
    fix_val = 0;
    for (int k = 0; k < 2; k++) begin
      fix_on[k] = 0;
      rf_rdata[k] = 0;
      for (int n = 0; n < 2; n++) begin
        req[k][n] = 0; rwn[k][n] = 0; addr[k][n] = 0; wd[k][n] = 0;
      end
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);

    fix_on[0] = 1; fix_val = 32'hDEADBEEF;
    txn("t1_rd", 0, 0, 1'b1, 7'h02, 32'd0, 1, 3, 1'b0, -1, 32'hDEADBEEF);
    fix_on[0] = 0;
    txn("t2_wr", 0, 1, 1'b0, 7'h03, 32'h000000FF, 1, 2, 1'b0, -2, 32'd0);
    @(negedge clk);
    chk("t2_m1_rdata_kept", 0, {32'd0, rdata[0][1]}, 64'd0);

    @(posedge clk); #1;
    req[0][0] = 1; rwn[0][0] = 1; addr[0][0] = 7'h04;
    req[0][1] = 1; rwn[0][1] = 1; addr[0][1] = 7'h05;
    both = 0;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      @(negedge clk);
      if (ack[0][0] && ack[0][1]) both++;
      if (ack[0][0]) order.push_back(0);
      else if (ack[0][1]) order.push_back(1);
      @(posedge clk); #1;
    end
    req[0][0] = 0; req[0][1] = 0;
    chk("t3_ack_count", 0, 64'(order.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_grant_order", 0, 64'((order.size() > i) ? order[i] : 9), 64'(i % 2));
    chk("t3_acks_coincide", 0, 64'(both), 64'd0);

    txn("t4_wr_ro", 0, 0, 1'b0, 7'h00, 32'h12345678, -1, 2, 1'b1, -2, 32'd0);
    txn("t4_rd_unmapped", 0, 1, 1'b1, 7'h60, 32'd0, -1, 2, 1'b1, -1, 32'd0);
    txn("t4_wr_ro_top", 0, 0, 1'b0, RO_TOP, 32'hA5A5A5A5, 1, 2, 1'b0, -2, 32'd0);
    txn("t4_rd_past_max", 0, 1, 1'b1, MAXA + 7'd1, 32'd0, -1, 2, 1'b1, -1, 32'd0);

    @(posedge clk); #1;
    req[0][0] = 1; rwn[0][0] = 1; addr[0][0] = 7'h10; s5 = cyc;
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_in_wait", 0, 64'(cyc - s5), 64'd2);
    rst_n = 0;
    @(negedge clk);
    chk("t5_rst_en", 0, {63'd0, rf_en[0]}, 64'd0);
    chk("t5_rst_ack", 0, {63'd0, ack[0][0]}, 64'd0);
    chk("t5_rst_rdata", 0, {32'd0, rdata[0][0]}, 64'd0);
    @(posedge clk); #1;
    req[0][0] = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk);
    txn("t5_fresh_rd", 0, 0, 1'b1, 7'h11, 32'd0, 1, 3, 1'b0, 2, 32'd0);

    txn("t6_rd_max_lat3", 1, 0, 1'b1, MAXA, 32'd0, 1, 5, 1'b0, 4, 32'd0);

    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      if (t == 1500) rst_n = 0;
      if (t == 1503) rst_n = 1;
      for (int k = 0; k < 2; k++) begin
        for (int n = 0; n < 2; n++) begin
          if (req[k][n]) begin
            if (ack_prev[k][n]) begin
              if ($urandom_range(0, 2) != 0) new_fields(k, n);
              else req[k][n] = 0;
            end else if ($urandom_range(0, 63) == 0) begin
              req[k][n] = 0;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            req[k][n] = 1;
            new_fields(k, n);
          end
        end
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      req[k][0] = 0;
      req[k][1] = 0;
    end
    repeat (12) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
